// File: rtl/y_adder.sv
// ---------------------------------------------------------------------------
// y_adder -- WIDTH-bit ripple-carry adder, z = a + b + cin, with carry-out.
//
// Datapath adder for the ALU/CPU lab blocks. Addition only: callers that
// need subtraction invert b themselves and drive cin = 1.
//
// Two views of the result:
//   * combinational z/cout, zero latency, pure function of a/b/cin
//   * registered z_r/cout_r/valid_r, captured on clk when in_valid is high
//
// Ports
//   clk      in   1      rising-edge clock for the output register stage
//   rst      in   1      async active-high reset, clears register stage only
//   a        in   WIDTH  operand A (sign-agnostic bit pattern)
//   b        in   WIDTH  operand B
//   cin      in   1      carry into bit 0
//   in_valid in   1      qualifies a/b/cin for capture
//   z        out  WIDTH  combinational sum (low WIDTH bits of a+b+cin)
//   cout     out  1      combinational carry out of bit WIDTH-1
//   z_r      out  WIDTH  registered z
//   cout_r   out  1      registered cout
//   valid_r  out  1      high the cycle after a captured in_valid
//   ovf      out  1      signed overflow, combinational   (YADDER_OVERFLOW_EN)
//   ovf_r    out  1      registered ovf                    (YADDER_OVERFLOW_EN)
//
// Optional feature macro: YADDER_OVERFLOW_EN
//   Defined   -> adds ovf/ovf_r two's-complement overflow outputs.
//   Undefined -> those ports and their logic are absent.
//
// Parameter
//   WIDTH  operand/sum width in bits, must be >= 2 (default 32)
// ---------------------------------------------------------------------------

// One full-adder slice of the ripple chain.
module y_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    // Propagate term is shared by sum and carry.
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module y_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic [WIDTH-1:0] z_r,
    output logic             cout_r,
    output logic             valid_r
`ifdef YADDER_OVERFLOW_EN
    ,
    output logic             ovf,
    output logic             ovf_r
`endif
);

    // Carry chain: w_c[0] is cin, w_c[WIDTH] is the carry out.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_valid;

    assign w_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            y_adder_fa u_fa (
                .i_a (a[gi]),
                .i_b (b[gi]),
                .i_c (w_c[gi]),
                .o_s (w_s[gi]),
                .o_c (w_c[gi+1])
            );
        end
    endgenerate

    assign z    = w_s;
    assign cout = w_c[WIDTH];

    // Result registers hold when in_valid is low; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_z    <= w_s;
                r_cout <= w_c[WIDTH];
            end
        end
    end

    assign z_r     = r_z;
    assign cout_r  = r_cout;
    assign valid_r = r_valid;

`ifdef YADDER_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf   = w_ovf;
    assign ovf_r = r_ovf;
`endif

endmodule

// File: tb/tb_y_adder.sv
module tb_y_adder;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic [WIDTH-1:0] z_r;
    logic             cout_r;
    logic             valid_r;
`ifdef YADDER_OVERFLOW_EN
    logic             ovf;
    logic             ovf_r;
`endif

    int n_chk;
    int n_fail;

    y_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .z        (z),
        .cout     (cout),
        .z_r      (z_r),
        .cout_r   (cout_r),
        .valid_r  (valid_r)
`ifdef YADDER_OVERFLOW_EN
        ,
        .ovf      (ovf),
        .ovf_r    (ovf_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a combinational vector and check after settle time.
    task automatic comb_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                            input logic vc, input logic [31:0] ez, input logic ec, input logic eo);
        a = va; b = vb; cin = vc;
        #1;
        chk({tag, ".z"}, 64'(z), 64'(ez));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
`ifdef YADDER_OVERFLOW_EN
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) n_chk = n_chk; // overflow not built; expectation unused
`endif
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] usum;
        logic signed [32:0] ssum;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;

        // Reset state
        #1;
        chk("rst.z_r",     64'(z_r),     64'h0);
        chk("rst.cout_r",  64'(cout_r),  64'h0);
        chk("rst.valid_r", 64'(valid_r), 64'h0);

        // Combinational vectors, hand-computed
        comb_vec("v1p1",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
        comb_vec("ffp1",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        comb_vec("maxpos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        comb_vec("ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        comb_vec("zeros",  32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        comb_vec("minneg", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        comb_vec("cinonly",32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0);
        comb_vec("alt",    32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0);

        // Registers stay cleared while rst is held across an edge
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rsthold.valid_r", 64'(valid_r), 64'h0);
        chk("rsthold.z_r",     64'(z_r),     64'h0);

        // Release reset, single capture
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1;
        a = 32'h12345678; b = 32'h11111111; cin = 1'b1;
        #1;
        chk("cap.z_comb", 64'(z), 64'h2345678A);
        @(posedge clk); #1;
        chk("cap.z_r",     64'(z_r),     64'h2345678A);
        chk("cap.cout_r",  64'(cout_r),  64'h0);
        chk("cap.valid_r", 64'(valid_r), 64'h1);
        @(negedge clk);
        in_valid = 1'b0; a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0;
        @(posedge clk); #1;
        chk("hold.valid_r", 64'(valid_r), 64'h0);
        chk("hold.z_r",     64'(z_r),     64'h2345678A);
        chk("hold.cout_r",  64'(cout_r),  64'h0);

        // Back-to-back captures
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0;
        @(posedge clk); #1;
        chk("b2b0.z_r",    64'(z_r),    64'h0);
        chk("b2b0.cout_r", 64'(cout_r), 64'h1);
`ifdef YADDER_OVERFLOW_EN
        chk("b2b0.ovf_r",  64'(ovf_r),  64'h0);
`endif
        a = 32'h7FFFFFFF; b = 32'h00000001; cin = 1'b0;
        @(posedge clk); #1;
        chk("b2b1.z_r",     64'(z_r),     64'h80000000);
        chk("b2b1.cout_r",  64'(cout_r),  64'h0);
        chk("b2b1.valid_r", 64'(valid_r), 64'h1);
`ifdef YADDER_OVERFLOW_EN
        chk("b2b1.ovf_r",   64'(ovf_r),   64'h1);
`endif

        // Mid-stream async reset between edges
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
        @(posedge clk); #1;
        chk("pre.cout_r", 64'(cout_r), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.z_r",     64'(z_r),     64'h0);
        chk("arst.cout_r",  64'(cout_r),  64'h0);
        chk("arst.valid_r", 64'(valid_r), 64'h0);
`ifdef YADDER_OVERFLOW_EN
        chk("arst.ovf_r",   64'(ovf_r),   64'h0);
`endif
        a = 32'h00000010; b = 32'h00000020; cin = 1'b1;
        #1;
        chk("arst.z_track", 64'(z), 64'h00000031);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post.z_r",     64'(z_r),     64'h00000031);
        chk("post.valid_r", 64'(valid_r), 64'h1);

        // Random operands against unsigned and signed reference sums
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            a = ra; b = rb; cin = 1'b0;
            #1;
            usum = {1'b0, ra} + {1'b0, rb};
            ssum = $signed({ra[31], ra}) + $signed({rb[31], rb});
            chk($sformatf("rnd%0d.z_u", i), 64'(z), 64'(usum[31:0]));
            chk($sformatf("rnd%0d.cout", i), 64'(cout), 64'(usum[32]));
            chk($sformatf("rnd%0d.z_s", i), 64'(z), 64'(ssum[31:0]));
`ifdef YADDER_OVERFLOW_EN
            chk($sformatf("rnd%0d.ovf", i), 64'(ovf), 64'(ssum[32] ^ ssum[31]));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
